// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80 machine-cycle sequencer: bus kinds, T-states,
// the registered strobe bundle and its per-state decode.
package z80_bus_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        MEM_RD = 3'd1,
        MEM_WR = 3'd2,
        IO_RD  = 3'd3,
        IO_WR  = 3'd4
    } bus_kind_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        TW   = 3'd3,
        T3   = 3'd4,
        T4   = 3'd5
    } tstate_e;

    localparam int FETCH_T = 4;
    localparam int MEM_T   = 3;
    localparam int IO_T    = 3;

    typedef struct packed {
        logic m1_n;
        logic mreq_n;
        logic iorq_n;
        logic rd_n;
        logic wr_n;
        logic rfsh_n;
    } strobe_t;

    localparam strobe_t STB_OFF = '1;

    function automatic logic is_io(input logic [2:0] kind);
        return (kind == IO_RD) || (kind == IO_WR);
    endfunction

    function automatic logic is_reserved(input logic [2:0] kind);
        return kind > IO_WR;
    endfunction

    // Strobe levels the bus must show while in state st of a cycle of this kind.
    function automatic strobe_t strobes_for(input tstate_e st, input logic [2:0] kind);
        strobe_t s;
        s = STB_OFF;
        if (st != IDLE) begin
            case (kind)
                FETCH: begin
                    s.mreq_n = 1'b0;
                    if (st == T3 || st == T4) begin
                        s.rfsh_n = 1'b0;
                    end else begin
                        s.m1_n = 1'b0;
                        s.rd_n = 1'b0;
                    end
                end
                MEM_RD: begin
                    s.mreq_n = 1'b0;
                    s.rd_n   = 1'b0;
                end
                MEM_WR: begin
                    s.mreq_n = 1'b0;
                    s.wr_n   = (st == T1);
                end
                IO_RD: if (st != T1) begin
                    s.iorq_n = 1'b0;
                    s.rd_n   = 1'b0;
                end
                IO_WR: if (st != T1) begin
                    s.iorq_n = 1'b0;
                    s.wr_n   = 1'b0;
                end
                default: s = STB_OFF;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/z80_refresh_ctr.sv
// Z80 R register: low 7 bits count refresh cycles, bit 7 only changes on load.
module z80_refresh_ctr (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_inc,
    input  logic       i_ld,
    input  logic [7:0] i_ld_val,
    output logic [7:0] o_r
);

    logic [7:0] r_r;

    // NOTE: non-blocking assignments for every register so all flops sample pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_r <= 8'h00;
        end else if (i_ld) begin
            r_r <= i_ld_val;
        end else if (i_inc) begin
            r_r <= {r_r[7], r_r[6:0] + 7'd1};
        end
    end

    assign o_r = r_r;

endmodule

// File: rtl/z80_bus_seq.sv
// Z80 machine-cycle sequencer: turns one-shot bus requests into registered
// T-state strobe sequences with WAIT_n stretching, IO auto-wait and refresh.
module z80_bus_seq
    import z80_bus_pkg::*;
#(
    parameter int ADDR_W       = 20,
    parameter int IO_AUTO_WAIT = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Run,
    input  logic              req,
    input  logic [2:0]        req_kind,
    input  logic [15:0]       req_addr,
    input  logic [7:0]        req_wdata,
    input  logic [ADDR_W-17:0] bank,
    input  logic [7:0]        ireg,
    output logic              ack,
    output logic              done,
    output logic [7:0]        rdata,
    output logic [ADDR_W-1:0] ADDR,
    input  logic [7:0]        Data_in,
    output logic [7:0]        Data_out,
    output logic              data_oe,
    output logic              M1_n,
    output logic              MREQ_n,
    output logic              IORQ_n,
    output logic              RD_n,
    output logic              WR_n,
    output logic              RFSH_n,
    input  logic              WAIT_n,
    output logic [2:0]        State_curr
);

    localparam logic [3:0] IOW_LOAD = (IO_AUTO_WAIT > 0) ? 4'(IO_AUTO_WAIT - 1) : 4'd0;

    tstate_e           r_state, w_next;
    logic [2:0]        r_kind, w_kind;
    logic [15:0]       r_addr, w_addr;
    logic [7:0]        r_wdata, w_wdata;
    logic [3:0]        r_iow;
    strobe_t           r_stb, w_stb;
    logic [ADDR_W-1:0] r_addr_out, w_bus_addr;
    logic [7:0]        r_dout, r_rdata;
    logic              r_oe, r_done;
    logic              w_final, w_accept, w_forced, w_is_wr, w_r_inc;
    logic [7:0]        w_r;

    z80_refresh_ctr u_rctr (
        .i_clk   (Clk),
        .i_rst_n (Reset),
        .i_inc   (w_r_inc),
        .i_ld    (1'b0),
        .i_ld_val(8'h00),
        .o_r     (w_r)
    );

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        w_final  = (r_state == T1 && is_reserved(r_kind)) ||
                   (r_state == T3 && r_kind != FETCH) || (r_state == T4);
        w_accept = req && Run && (r_state == IDLE || w_final);
        w_kind   = w_accept ? req_kind  : r_kind;
        w_addr   = w_accept ? req_addr  : r_addr;
        w_wdata  = w_accept ? req_wdata : r_wdata;
        // IO cycles ignore WAIT_n until their forced wait states have elapsed.
        w_forced = is_io(r_kind) && ((r_state == T2) ? (IO_AUTO_WAIT != 0) : (r_iow != 4'd0));
        w_next   = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? T1 : IDLE;
            T1:      w_next = is_reserved(r_kind) ? (w_accept ? T1 : IDLE) : T2;
            T2, TW:  w_next = (w_forced || !WAIT_n) ? TW : T3;
            T3:      w_next = (r_kind == FETCH) ? T4 : (w_accept ? T1 : IDLE);
            T4:      w_next = w_accept ? T1 : IDLE;
            default: w_next = IDLE;
        endcase
        w_stb   = strobes_for(w_next, w_kind);
        w_is_wr = (w_kind == MEM_WR || w_kind == IO_WR) && w_next != IDLE && w_next != T4;
        if (w_kind == FETCH && (w_next == T3 || w_next == T4)) begin
            w_bus_addr = {{(ADDR_W-16){1'b0}}, ireg, w_r};
        end else if (is_io(w_kind)) begin
            w_bus_addr = {{(ADDR_W-16){1'b0}}, w_addr};
        end else begin
            w_bus_addr = {bank, w_addr};
        end
        w_r_inc = (r_state == T4);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= IDLE;
            r_kind     <= 3'd0;
            r_addr     <= 16'h0000;
            r_wdata    <= 8'h00;
            r_iow      <= 4'd0;
            r_stb      <= STB_OFF;
            r_addr_out <= '0;
            r_dout     <= 8'h00;
            r_oe       <= 1'b0;
            r_rdata    <= 8'h00;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_kind  <= w_kind;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_stb   <= w_stb;
            r_done  <= w_final;
            r_oe    <= w_is_wr;
            if (r_state == T2) begin
                r_iow <= IOW_LOAD;
            end else if (r_iow != 4'd0) begin
                r_iow <= r_iow - 4'd1;
            end
            if (w_next != IDLE) begin
                r_addr_out <= w_bus_addr;
            end
            if (w_is_wr) begin
                r_dout <= w_wdata;
            end
            // Opcode data is captured before refresh takes over the bus; other reads at the end of T3.
            if ((r_state == T2 || r_state == TW) && w_next == T3 && r_kind == FETCH) begin
                r_rdata <= Data_in;
            end else if (r_state == T3 && (r_kind == MEM_RD || r_kind == IO_RD)) begin
                r_rdata <= Data_in;
            end
        end
    end

    assign ack        = w_accept;
    assign done       = r_done;
    assign rdata      = r_rdata;
    assign ADDR       = r_addr_out;
    assign Data_out   = r_dout;
    assign data_oe    = r_oe;
    assign M1_n       = r_stb.m1_n;
    assign MREQ_n     = r_stb.mreq_n;
    assign IORQ_n     = r_stb.iorq_n;
    assign RD_n       = r_stb.rd_n;
    assign WR_n       = r_stb.wr_n;
    assign RFSH_n     = r_stb.rfsh_n;
    assign State_curr = r_state;

endmodule

// File: tb/tb_z80_bus_seq.sv
// Directed bench for z80_bus_seq: fetch/refresh, waits, IO auto-wait,
// back-to-back cycles, Run gating, reset abort and R wrap.
module tb_z80_bus_seq;
    import z80_bus_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset, Run, req, WAIT_n;
    logic [2:0]  req_kind;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata, ireg, Data_in;
    logic [3:0]  bank;
    logic        ack, done, data_oe;
    logic [7:0]  rdata, Data_out;
    logic [19:0] ADDR;
    logic        M1_n, MREQ_n, IORQ_n, RD_n, WR_n, RFSH_n;
    logic [2:0]  State_curr;
    logic [5:0]  stb;

    logic        rc_inc, rc_ld;
    logic [7:0]  rc_ld_val, rc_r;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  r_model;

    // Strobe patterns as {M1_n, MREQ_n, IORQ_n, RD_n, WR_n, RFSH_n}.
    localparam logic [5:0] S_OFF  = 6'b111111;
    localparam logic [5:0] S_M1   = 6'b001011;
    localparam logic [5:0] S_RFSH = 6'b101110;
    localparam logic [5:0] S_MRD  = 6'b101011;
    localparam logic [5:0] S_MWT1 = 6'b101111;
    localparam logic [5:0] S_MWR  = 6'b101101;
    localparam logic [5:0] S_IORD = 6'b110011;

    always #5 Clk = ~Clk;
    assign stb = {M1_n, MREQ_n, IORQ_n, RD_n, WR_n, RFSH_n};

    z80_bus_seq #(.ADDR_W(20), .IO_AUTO_WAIT(1)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .req(req), .req_kind(req_kind),
        .req_addr(req_addr), .req_wdata(req_wdata), .bank(bank), .ireg(ireg),
        .ack(ack), .done(done), .rdata(rdata), .ADDR(ADDR), .Data_in(Data_in),
        .Data_out(Data_out), .data_oe(data_oe), .M1_n(M1_n), .MREQ_n(MREQ_n),
        .IORQ_n(IORQ_n), .RD_n(RD_n), .WR_n(WR_n), .RFSH_n(RFSH_n),
        .WAIT_n(WAIT_n), .State_curr(State_curr)
    );

    z80_refresh_ctr u_rc (
        .i_clk(Clk), .i_rst_n(Reset), .i_inc(rc_inc), .i_ld(rc_ld),
        .i_ld_val(rc_ld_val), .o_r(rc_r)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_t(input string tag, input tstate_e st, input logic [5:0] s, input logic [19:0] a);
        check({tag, " state"}, 32'(State_curr), 32'(st));
        check({tag, " strobes"}, 32'(stb), 32'(s));
        check({tag, " addr"}, 32'(ADDR), 32'(a));
    endtask

    task automatic start(input logic [2:0] kind, input logic [15:0] a, input logic [7:0] wd);
        req = 1'b1; req_kind = kind; req_addr = a; req_wdata = wd;
        #1;
        check("ack", 32'(ack), 32'd1);
        step();
        req = 1'b0;
    endtask

    task automatic fetch(input logic [15:0] a, input logic [7:0] din);
        logic [19:0] ra;
        ra = {4'h0, ireg, r_model};
        start(3'd0, a, 8'h00);
        Data_in = din;
        chk_t("fetch T1", T1, S_M1, {bank, a});
        step();
        chk_t("fetch T2", T2, S_M1, {bank, a});
        step();
        Data_in = 8'h00;
        chk_t("fetch T3", T3, S_RFSH, ra);
        step();
        chk_t("fetch T4", T4, S_RFSH, ra);
        step();
        r_model = {r_model[7], r_model[6:0] + 7'd1};
        check("fetch done", 32'(done), 32'd1);
        check("fetch rdata", 32'(rdata), 32'(din));
        check("fetch end state", 32'(State_curr), 32'(IDLE));
        check("fetch end strobes", 32'(stb), 32'(S_OFF));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; Run = 1'b1; req = 1'b0; req_kind = 3'd0; req_addr = 16'h0;
        req_wdata = 8'h00; bank = 4'h2; ireg = 8'h5A; Data_in = 8'h00; WAIT_n = 1'b1;
        rc_inc = 1'b0; rc_ld = 1'b0; rc_ld_val = 8'h00; r_model = 8'h00;
        #2 Reset = 1'b0;
        step();
        step();
        chk_t("reset", IDLE, S_OFF, 20'h0);
        check("reset data_oe", 32'(data_oe), 32'd0);
        check("reset Data_out", 32'(Data_out), 32'd0);
        check("reset rdata", 32'(rdata), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset ack", 32'(ack), 32'd0);
        Reset = 1'b1;
        step();

        // Basic fetch: ADDR 21234, refresh 05A00, rdata 3E, then done drops.
        fetch(16'h1234, 8'h3E);
        step();
        check("done pulse width", 32'(done), 32'd0);
        fetch(16'h0001, 8'h77);

        // Reset asserted in T2 of a fetch aborts at once.
        start(3'd0, 16'h4000, 8'h00);
        step();
        check("abort pre state", 32'(State_curr), 32'(T2));
        #2 Reset = 1'b0;
        #1;
        check("abort state", 32'(State_curr), 32'(IDLE));
        check("abort strobes", 32'(stb), 32'(S_OFF));
        r_model = 8'h00;
        step();
        Reset = 1'b1;
        check("abort rdata", 32'(rdata), 32'd0);
        check("abort addr", 32'(ADDR), 32'd0);
        fetch(16'h2222, 8'h01);

        // Memory write stretched by two wait states.
        start(3'd2, 16'h8000, 8'hA5);
        chk_t("wr T1", T1, S_MWT1, 20'h28000);
        check("wr T1 oe", 32'(data_oe), 32'd1);
        check("wr T1 dout", 32'(Data_out), 32'hA5);
        WAIT_n = 1'b0;
        step();
        chk_t("wr T2", T2, S_MWR, 20'h28000);
        step();
        chk_t("wr TW1", TW, S_MWR, 20'h28000);
        step();
        chk_t("wr TW2", TW, S_MWR, 20'h28000);
        check("wr TW2 dout", 32'(Data_out), 32'hA5);
        WAIT_n = 1'b1;
        step();
        chk_t("wr T3", T3, S_MWR, 20'h28000);
        check("wr T3 oe", 32'(data_oe), 32'd1);
        step();
        check("wr done", 32'(done), 32'd1);
        check("wr oe drop", 32'(data_oe), 32'd0);
        check("wr end strobes", 32'(stb), 32'(S_OFF));

        // IO read: one forced wait even with WAIT_n high, no bank bits.
        start(3'd3, 16'h00FE, 8'h00);
        chk_t("io T1", T1, S_OFF, 20'h000FE);
        step();
        chk_t("io T2", T2, S_IORD, 20'h000FE);
        step();
        chk_t("io TW", TW, S_IORD, 20'h000FE);
        step();
        chk_t("io T3", T3, S_IORD, 20'h000FE);
        Data_in = 8'hC7;
        step();
        Data_in = 8'h00;
        check("io done", 32'(done), 32'd1);
        check("io rdata", 32'(rdata), 32'hC7);

        // Three back-to-back memory reads; Run drops during the third.
        req = 1'b1; req_kind = 3'd1; req_addr = 16'h0100;
        #1;
        check("b2b ack idle", 32'(ack), 32'd1);
        step();
        for (int c = 0; c < 3; c++) begin
            chk_t("b2b T1", T1, S_MRD, 20'h20100);
            check("b2b T1 ack", 32'(ack), 32'd0);
            if (c > 0) begin
                check("b2b done", 32'(done), 32'd1);
                check("b2b rdata", 32'(rdata), 32'(8'(8'h11 * c)));
            end
            step();
            chk_t("b2b T2", T2, S_MRD, 20'h20100);
            if (c == 2) Run = 1'b0;
            #1;
            check("b2b T2 ack", 32'(ack), 32'd0);
            step();
            chk_t("b2b T3", T3, S_MRD, 20'h20100);
            Data_in = 8'(8'h11 * (c + 1));
            #1;
            check("b2b T3 ack", 32'(ack), (c < 2) ? 32'd1 : 32'd0);
            step();
        end
        check("b2b last state", 32'(State_curr), 32'(IDLE));
        check("b2b last done", 32'(done), 32'd1);
        check("b2b last rdata", 32'(rdata), 32'h33);
        check("b2b no ack", 32'(ack), 32'd0);
        step();
        check("b2b stays idle", 32'(State_curr), 32'(IDLE));
        check("b2b still no ack", 32'(ack), 32'd0);
        req = 1'b0; Run = 1'b1; Data_in = 8'h00;

        // Reserved kind: acked, no strobes, done follows.
        start(3'd5, 16'h1111, 8'h00);
        check("rsv state", 32'(State_curr), 32'(T1));
        check("rsv strobes", 32'(stb), 32'(S_OFF));
        step();
        check("rsv done", 32'(done), 32'd1);
        check("rsv end state", 32'(State_curr), 32'(IDLE));
        check("rsv end strobes", 32'(stb), 32'(S_OFF));
        step();

        // 128 fetches carry R through 7F -> 00 with bit 7 held.
        for (int i = 0; i < 128; i++) begin
            fetch(16'(i), 8'(i ^ 8'h55));
        end
        check("r wrap model", 32'(r_model), 32'h01);

        // R register alone: FF -> 80, 7E -> 7F -> 00, hold when idle.
        rc_ld = 1'b1; rc_ld_val = 8'hFF;
        step();
        rc_ld = 1'b0;
        check("rctr load", 32'(rc_r), 32'hFF);
        rc_inc = 1'b1;
        step();
        rc_inc = 1'b0;
        check("rctr FF inc", 32'(rc_r), 32'h80);
        step();
        check("rctr hold", 32'(rc_r), 32'h80);
        rc_ld = 1'b1; rc_ld_val = 8'h7E;
        step();
        rc_ld = 1'b0; rc_inc = 1'b1;
        step();
        check("rctr 7E inc", 32'(rc_r), 32'h7F);
        step();
        rc_inc = 1'b0;
        check("rctr 7F inc", 32'(rc_r), 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
